// File: rtl/apb2fifo_mc.sv
// Multi-channel APB slave bridge: APB writes become outbound FIFO words, inbound FIFO words
// update per-channel shadow registers that APB reads return.
module apb2fifo_mc #(
   parameter int NCH     = 4,
   parameter int DATA_W  = 32,
   parameter int CFG_W   = 16,
   parameter int MODE_W  = 2,
   parameter int TIMEOUT = 255,
   parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic [15:0]              paddr,
   input  logic                     psel,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [31:0]              pwdata,
   output logic                     pready,
   output logic [31:0]              prdata,
   output logic                     pslverr,
   output logic [CH_W+DATA_W+1:0]   fifo_write_data,
   output logic                     fifo_write_inc,
   input  logic                     fifo_write_full,
   input  logic                     fifo_write_empty,
   input  logic [CH_W+DATA_W+1:0]   fifo_read_data,
   input  logic                     fifo_read_empty,
   output logic                     fifo_read_inc,
   output logic [NCH-1:0]           irq
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t                 state, nxt_state;
   logic [3:0]             a_ch;
   logic [1:0]             a_mod;
   logic                   a_write, a_bad;
   logic [DATA_W-1:0]      a_wdata;
   logic [CNT_W-1:0]       cnt, nxt_cnt;
   logic                   nxt_pready, nxt_pslverr, nxt_inc, rd_clr;
   logic [31:0]            nxt_prdata, rd_val;
   logic [CH_W+DATA_W+1:0] nxt_wdata;

   logic [DATA_W-1:0]      dat  [NCH];
   logic [CFG_W-1:0]       cfg  [NCH];
   logic [MODE_W-1:0]      mode [NCH];
   logic [5:0]             st   [NCH];
   logic [NCH-1:0]         wrf, ovr;

   logic [CH_W-1:0]        ach, in_ch;
   logic [1:0]             in_mod;
   logic [DATA_W-1:0]      in_data;
   logic [3:0]             off;
   logic                   setup;
   logic                   unused_addr;

   assign ach           = a_ch[CH_W-1:0];
   assign off           = paddr[3:0];
   assign setup         = psel & ~penable;
   assign {in_ch, in_mod, in_data} = fifo_read_data;
   assign fifo_read_inc = ~fifo_read_empty & ~preset;
   assign unused_addr   = &{1'b0, paddr[15:8]};

   always_comb begin
      irq = '0;
      for (int c = 0; c < NCH; c++) begin
         irq[c] = wrf[c] & st[c][0];
      end
   end

   // Register file read mux; STATUS full/empty bits reflect the outbound FIFO at the read edge.
   always_comb begin
      case (a_mod)
         2'd0:    rd_val = 32'(cfg[ach]);
         2'd1:    rd_val = 32'(dat[ach]);
         2'd2:    rd_val = 32'({fifo_write_empty, fifo_write_full, st[ach], ovr[ach], wrf[ach]});
         default: rd_val = 32'(mode[ach]);
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         a_ch    <= 4'd0;
         a_mod   <= 2'd0;
         a_write <= 1'b0;
         a_wdata <= '0;
         a_bad   <= 1'b0;
      end else if (state == IDLE && setup) begin
         a_ch    <= paddr[7:4];
         a_mod   <= off[1:0] - 2'd1;
         a_write <= pwrite;
         a_wdata <= pwdata[DATA_W-1:0];
         a_bad   <= (off == 4'd0) || (off > 4'd4) || (int'(paddr[7:4]) >= NCH);
      end else begin
         a_ch    <= a_ch;
      end
   end

   always_comb begin
      nxt_state   = state;
      nxt_pready  = 1'b0;
      nxt_pslverr = 1'b0;
      nxt_inc     = 1'b0;
      nxt_prdata  = prdata;
      nxt_wdata   = fifo_write_data;
      nxt_cnt     = cnt;
      rd_clr      = 1'b0;
      case (state)
         IDLE: begin
            if (setup) nxt_state = ACCESS;
            else       nxt_state = IDLE;
         end
         ACCESS: begin
            if (a_bad || (a_write && a_mod == 2'd2)) begin
               nxt_pready  = 1'b1;
               nxt_pslverr = 1'b1;
               nxt_state   = DONE;
            end else if (!a_write) begin
               nxt_prdata = rd_val;
               nxt_pready = 1'b1;
               rd_clr     = (a_mod == 2'd1);
               nxt_state  = DONE;
            end else if (!fifo_write_full) begin
               nxt_wdata  = {ach, a_mod, a_wdata};
               nxt_inc    = 1'b1;
               nxt_pready = 1'b1;
               nxt_state  = DONE;
            end else begin
               nxt_cnt   = '0;
               nxt_state = WAIT;
            end
         end
         WAIT: begin
            if (!fifo_write_full) begin
               nxt_wdata  = {ach, a_mod, a_wdata};
               nxt_inc    = 1'b1;
               nxt_pready = 1'b1;
               nxt_state  = DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               nxt_pready  = 1'b1;
               nxt_pslverr = 1'b1;
               nxt_state   = DONE;
            end else begin
               nxt_cnt = cnt + CNT_W'(1);
            end
         end
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state           <= IDLE;
         pready          <= 1'b0;
         pslverr         <= 1'b0;
         prdata          <= 32'd0;
         fifo_write_inc  <= 1'b0;
         fifo_write_data <= '0;
         cnt             <= '0;
      end else begin
         state           <= nxt_state;
         pready          <= nxt_pready;
         pslverr         <= nxt_pslverr;
         prdata          <= nxt_prdata;
         fifo_write_inc  <= nxt_inc;
         fifo_write_data <= nxt_wdata;
         cnt             <= nxt_cnt;
      end
   end

   // Shadow registers; an inbound DATA word beats a simultaneous DATA-read clear of WRF.
   always_ff @(posedge pclk) begin
      if (preset) begin
         wrf <= '0;
         ovr <= '0;
         for (int c = 0; c < NCH; c++) begin
            dat[c]  <= '0;
            cfg[c]  <= '0;
            mode[c] <= '0;
            st[c]   <= 6'd0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (fifo_read_inc && in_ch == CH_W'(c) && in_mod == 2'd1) begin
               dat[c] <= in_data;
               wrf[c] <= 1'b1;
               ovr[c] <= (rd_clr && ach == CH_W'(c)) ? 1'b0 : (ovr[c] | wrf[c]);
            end else if (rd_clr && ach == CH_W'(c)) begin
               wrf[c] <= 1'b0;
               ovr[c] <= 1'b0;
            end else begin
               wrf[c] <= wrf[c];
            end
            if (fifo_read_inc && in_ch == CH_W'(c)) begin
               case (in_mod)
                  2'd0:    cfg[c]  <= in_data[CFG_W-1:0];
                  2'd2:    st[c]   <= in_data[7:2];
                  2'd3:    mode[c] <= in_data[MODE_W-1:0];
                  default: st[c]   <= st[c];
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_apb2fifo_mc.sv
// Self-checking bench for apb2fifo_mc: constant vector table, hand-written corner sequences
// and randomized traffic against a register-map level reference model.
module tb_apb2fifo_mc;
   localparam int TIMEOUT = 255;

   logic        pclk = 1'b0;
   logic        preset, psel, penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;
   logic [35:0] fifo_write_data, fifo_read_data;
   logic        fifo_write_inc, fifo_write_full, fifo_write_empty;
   logic        fifo_read_empty, fifo_read_inc;
   logic [3:0]  irq;

   int checks = 0;
   int errors = 0;

   // reference model of the four channels' register banks
   logic [31:0] m_cfg [4];
   logic [31:0] m_dat [4];
   logic [31:0] m_mode[4];
   logic [7:0]  m_stat[4];
   bit          m_wrf [4];
   bit          m_ovr [4];

   apb2fifo_mc #(.TIMEOUT(TIMEOUT)) dut (
      .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .fifo_write_data(fifo_write_data), .fifo_write_inc(fifo_write_inc),
      .fifo_write_full(fifo_write_full), .fifo_write_empty(fifo_write_empty),
      .fifo_read_data(fifo_read_data), .fifo_read_empty(fifo_read_empty),
      .fifo_read_inc(fifo_read_inc), .irq(irq)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [15:0] addr;
      bit          wr;
      logic [31:0] wd;
      int          full;
      bit          exp_err;
      int          exp_push;
      logic [35:0] exp_word;
      bit          chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_cfg[c] = 32'd0; m_dat[c] = 32'd0; m_mode[c] = 32'd0; m_stat[c] = 8'd0;
         m_wrf[c] = 1'b0;  m_ovr[c] = 1'b0;
      end
   endtask

   task automatic model_in(input logic [35:0] w);
      int c;
      c = int'(w[35:34]);
      case (w[33:32])
         2'd0: m_cfg[c] = w[31:0] & 32'h0000_FFFF;
         2'd1: begin
            if (m_wrf[c]) m_ovr[c] = 1'b1;
            m_wrf[c] = 1'b1;
            m_dat[c] = w[31:0];
         end
         2'd2: m_stat[c] = {w[7:2], 2'b00};
         default: m_mode[c] = w[31:0] & 32'h0000_0003;
      endcase
   endtask

   function automatic logic [31:0] model_read(input int c, input int o);
      case (o)
         1: return m_cfg[c];
         2: return m_dat[c];
         3: return {22'd0, fifo_write_empty, 1'b0, m_stat[c][7:2], m_ovr[c], m_wrf[c]};
         default: return m_mode[c];
      endcase
   endfunction

   function automatic logic [3:0] model_irq();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = m_wrf[c] & m_stat[c][2];
      return v;
   endfunction

   task automatic send_in(input logic [35:0] w);
      fifo_read_empty = 1'b0;
      fifo_read_data  = w;
      #1;
      check("read_inc_on", {63'd0, fifo_read_inc}, 64'd1);
      tick();
      fifo_read_empty = 1'b1;
      model_in(w);
   endtask

   task automatic xfer(input logic [15:0] addr, input bit wr, input logic [31:0] wd, input int full_cyc,
                       input bit inj, input logic [35:0] inj_word,
                       output logic [31:0] rd, output bit err, output int n, output int pushes,
                       output logic [35:0] pword);
      pushes = 0; n = 0; pword = 36'd0;
      paddr = addr; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
      tick();
      penable = 1'b1;
      fifo_write_full = (full_cyc > 0);
      if (inj) begin
         fifo_read_empty = 1'b0;
         fifo_read_data  = inj_word;
      end
      while (n < 400) begin
         tick();
         n++;
         fifo_read_empty = 1'b1;
         if (fifo_write_inc) begin
            pushes++;
            pword = fifo_write_data;
         end
         if (pready) break;
         fifo_write_full = (n < full_cyc);
      end
      rd = prdata;
      err = pslverr;
      psel = 1'b0; penable = 1'b0; fifo_write_full = 1'b0;
      tick();
      if (fifo_write_inc) pushes++;
      check("done_clear", {62'd0, pready, pslverr}, 64'd0);
   endtask

   vec_t        tbl[12];
   logic [31:0] rd, exp_rd;
   bit          err;
   int          n, pushes, exp_n, ch, o, k;
   logic [35:0] pword, w;

   initial begin
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 16'd0; pwdata = 32'd0;
      fifo_write_full = 1'b0; fifo_write_empty = 1'b1; fifo_read_empty = 1'b0; fifo_read_data = 36'd0;
      model_reset();
      #1;
      check("read_inc_in_reset", {63'd0, fifo_read_inc}, 64'd0);
      fifo_read_empty = 1'b1;
      tick(); tick();
      preset = 1'b0;
      check("reset_outs", {pready, pslverr, fifo_write_inc, irq, fifo_read_inc}, 64'd0);
      check("reset_prdata", {32'd0, prdata}, 64'd0);
      check("reset_wdata", {28'd0, fifo_write_data}, 64'd0);

      tbl[0]  = '{16'h0003, 1'b0, 32'h0,    0,    1'b0, 0, 36'h0,           1'b1, 32'h200};
      tbl[1]  = '{16'h0021, 1'b1, 32'h1234, 0,    1'b0, 1, 36'h8_0000_1234, 1'b0, 32'h0};
      tbl[2]  = '{16'h0012, 1'b1, 32'hCAFE, 10,   1'b0, 1, 36'h5_0000_CAFE, 1'b0, 32'h0};
      tbl[3]  = '{16'h0014, 1'b1, 32'h3,    1000, 1'b1, 0, 36'h0,           1'b0, 32'h0};
      tbl[4]  = '{16'h0005, 1'b0, 32'h0,    0,    1'b1, 0, 36'h0,           1'b0, 32'h0};
      tbl[5]  = '{16'h0073, 1'b0, 32'h0,    0,    1'b1, 0, 36'h0,           1'b0, 32'h0};
      tbl[6]  = '{16'h0023, 1'b1, 32'h5,    0,    1'b1, 0, 36'h0,           1'b0, 32'h0};
      tbl[7]  = '{16'h0000, 1'b0, 32'h0,    0,    1'b1, 0, 36'h0,           1'b0, 32'h0};
      tbl[8]  = '{16'h0045, 1'b1, 32'h9,    0,    1'b1, 0, 36'h0,           1'b0, 32'h0};
      tbl[9]  = '{16'h0034, 1'b0, 32'h0,    0,    1'b0, 0, 36'h0,           1'b1, 32'h0};
      tbl[10] = '{16'h0011, 1'b0, 32'h0,    0,    1'b0, 0, 36'h0,           1'b1, 32'h0};
      tbl[11] = '{16'h0032, 1'b0, 32'h0,    0,    1'b0, 0, 36'h0,           1'b1, 32'h0};

      for (int i = 0; i < 12; i++) begin
         xfer(tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].full, 1'b0, 36'd0, rd, err, n, pushes, pword);
         exp_n = (tbl[i].full > TIMEOUT) ? TIMEOUT + 1 : tbl[i].full + 1;
         check($sformatf("tbl%0d_err", i), {63'd0, err}, {63'd0, tbl[i].exp_err});
         check($sformatf("tbl%0d_cycles", i), 64'(n), 64'(exp_n));
         check($sformatf("tbl%0d_pushes", i), 64'(pushes), 64'(tbl[i].exp_push));
         if (tbl[i].exp_push > 0) check($sformatf("tbl%0d_word", i), {28'd0, pword}, {28'd0, tbl[i].exp_word});
         if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), {32'd0, rd}, {32'd0, tbl[i].exp_rd});
      end

      // ch3: IE on, then two DATA words -> overrun and interrupt
      send_in({2'd3, 2'd2, 32'h0000_0004});
      send_in({2'd3, 2'd1, 32'h0000_000A});
      send_in({2'd3, 2'd1, 32'h0000_000B});
      check("irq3_set", {60'd0, irq}, 64'h8);
      xfer(16'h0033, 1'b0, 32'd0, 0, 1'b0, 36'd0, rd, err, n, pushes, pword);
      check("ch3_status_ovr", {32'd0, rd}, 64'h207);
      xfer(16'h0032, 1'b0, 32'd0, 0, 1'b0, 36'd0, rd, err, n, pushes, pword);
      check("ch3_data", {32'd0, rd}, 64'hB);
      m_wrf[3] = 1'b0; m_ovr[3] = 1'b0;
      xfer(16'h0033, 1'b0, 32'd0, 0, 1'b0, 36'd0, rd, err, n, pushes, pword);
      check("ch3_status_clr", {32'd0, rd}, 64'h204);
      check("irq3_clr", {60'd0, irq}, 64'h0);

      // DATA read of ch0 colliding with an inbound ch0 DATA word
      send_in({2'd0, 2'd1, 32'h0000_0011});
      xfer(16'h0002, 1'b0, 32'd0, 0, 1'b1, {2'd0, 2'd1, 32'h0000_0022}, rd, err, n, pushes, pword);
      check("collide_old", {32'd0, rd}, 64'h11);
      m_wrf[0] = 1'b0; m_ovr[0] = 1'b0;
      model_in({2'd0, 2'd1, 32'h0000_0022});
      xfer(16'h0003, 1'b0, 32'd0, 0, 1'b0, 36'd0, rd, err, n, pushes, pword);
      check("collide_wrf", {32'd0, rd}, 64'h201);
      xfer(16'h0002, 1'b0, 32'd0, 0, 1'b0, 36'd0, rd, err, n, pushes, pword);
      check("collide_new", {32'd0, rd}, 64'h22);
      m_wrf[0] = 1'b0; m_ovr[0] = 1'b0;

      for (int it = 0; it < 80; it++) begin
         ch = int'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0: begin
               w = {ch[1:0], 2'($urandom_range(0, 3)), 32'($urandom)};
               send_in(w);
            end
            1: begin
               o = int'($urandom_range(1, 4));
               fifo_write_empty = 1'($urandom_range(0, 1));
               exp_rd = model_read(ch, o);
               xfer(16'((ch << 4) | o), 1'b0, 32'd0, 0, 1'b0, 36'd0, rd, err, n, pushes, pword);
               check($sformatf("rnd_rd ch%0d off%0d", ch, o), {31'd0, err, rd}, {32'd0, exp_rd});
               if (o == 2) begin
                  m_wrf[ch] = 1'b0;
                  m_ovr[ch] = 1'b0;
               end
            end
            default: begin
               case ($urandom_range(0, 2))
                  0:       o = 1;
                  1:       o = 2;
                  default: o = 4;
               endcase
               k = int'($urandom_range(0, 3));
               w = {ch[1:0], 2'(o - 1), 32'($urandom)};
               xfer(16'((ch << 4) | o), 1'b1, w[31:0], k, 1'b0, 36'd0, rd, err, n, pushes, pword);
               check($sformatf("rnd_wr ch%0d off%0d", ch, o),
                     {1'b0, err, 10'(pushes), 16'(n), pword}, {1'b0, 1'b0, 10'd1, 16'(k + 1), w});
            end
         endcase
         check("rnd_irq", {60'd0, irq}, {60'd0, model_irq()});
      end
      fifo_write_empty = 1'b1;

      // reset in the middle of a full-FIFO wait
      send_in({2'd2, 2'd2, 32'h0000_0004});
      send_in({2'd2, 2'd1, 32'h0000_0055});
      check("irq2_set", {60'd0, irq}, {60'd0, model_irq()});
      paddr = 16'h0022; pwrite = 1'b1; pwdata = 32'h77; psel = 1'b1; penable = 1'b0;
      fifo_write_full = 1'b1;
      tick();
      penable = 1'b1;
      tick(); tick(); tick();
      preset = 1'b1;
      tick();
      check("wait_rst_outs", {pready, pslverr, fifo_write_inc, irq}, 64'd0);
      check("wait_rst_data", {prdata, fifo_write_data[31:0]}, 64'd0);
      preset = 1'b0; psel = 1'b0; penable = 1'b0; fifo_write_full = 1'b0;
      model_reset();
      pushes = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (fifo_write_inc || pready) pushes++;
      end
      check("wait_rst_quiet", 64'(pushes), 64'd0);
      xfer(16'h0023, 1'b0, 32'd0, 0, 1'b0, 36'd0, rd, err, n, pushes, pword);
      check("post_rst_status", {31'd0, err, rd}, 64'h200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
